// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the MIPS F-stage: redirect selects, FSM encoding
// and reset/bubble constants.
package fetch_stage_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned IMM_W    = 16;
  localparam int unsigned INDEX_W  = 26;
  localparam int unsigned PCCTL_W  = 2;

  // D-stage redirect select
  localparam logic [PCCTL_W-1:0] PC_SEQ = 2'd0;
  localparam logic [PCCTL_W-1:0] PC_BJ  = 2'd1;
  localparam logic [PCCTL_W-1:0] PC_REG = 2'd2;

  // Fetch FSM encoding
  localparam logic [0:0] ST_NORMAL  = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_3000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  // True when the D-stage controller asks for a non-sequential next PC
  function automatic logic is_redirect_sel(input logic [PCCTL_W-1:0] sel);
    return (sel == PC_BJ) || (sel == PC_REG);
  endfunction

endpackage

// File: rtl/fetch_stage_npc_calc.sv
// Combinational redirect-target computation for the D-stage instruction.
// Ports: pc_d, imm16_d, index26_d, rs_value_d, pc_control, npc_sel in;
//        target_c out (pc_d+4 when no redirect is selected).
module npc_calc
  import fetch_stage_pkg::*;
(
  input  logic [XLEN-1:0]    pc_d,
  input  logic [IMM_W-1:0]   imm16_d,
  input  logic [INDEX_W-1:0] index26_d,
  input  logic [XLEN-1:0]    rs_value_d,
  input  logic [PCCTL_W-1:0] pc_control,
  input  logic               npc_sel,
  output logic [XLEN-1:0]    target_c
);

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] branch_off;
  logic [XLEN-1:0] branch_tgt;
  logic [XLEN-1:0] jump_tgt;

  assign pc_plus4   = pc_d + XLEN'(4);
  // Sign-extended word offset, already shifted to a byte offset
  assign branch_off = {{(XLEN-IMM_W-2){imm16_d[IMM_W-1]}}, imm16_d, 2'b00};
  assign branch_tgt = pc_plus4 + branch_off;
  // Region-relative jump: keep the top nibble of the delay-slot PC
  assign jump_tgt   = {pc_plus4[XLEN-1:XLEN-4], index26_d, 2'b00};

  // Target select
  always_comb begin
    target_c = pc_plus4;
    case (pc_control)
      PC_BJ:   target_c = npc_sel ? jump_tgt : branch_tgt;
      PC_REG:  target_c = rs_value_d;
      default: target_c = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS F-stage: PC register, instruction-memory fetch, F/D pipeline register
// and a two-state FSM that parks a redirect while the delay-slot fetch waits
// on a slow instruction memory.
// Ports: clk, reset (async, active-high), stall, D-stage redirect inputs
//        (pc_control, npc_sel, imm16_d, index26_d, rs_value_d), imem_addr /
//        imem_rdata / imem_ready fetch interface, and F/D outputs pc_f,
//        instr_d, pc_d, pc_plus8_d, valid_d, adel_d.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic [1:0]          pc_control,
  input  logic                npc_sel,
  input  logic [15:0]         imm16_d,
  input  logic [25:0]         index26_d,
  input  logic [31:0]         rs_value_d,
  output logic [31:0]         imem_addr,
  input  logic [31:0]         imem_rdata,
  input  logic                imem_ready,
  output logic [31:0]         pc_f,
  output logic [31:0]         instr_d,
  output logic [31:0]         pc_d,
  output logic [31:0]         pc_plus8_d,
  output logic                valid_d,
  output logic                adel_d
);

  logic [0:0]      state;
  logic [0:0]      state_nxt;
  logic [XLEN-1:0] saved_target;
  logic [XLEN-1:0] saved_target_nxt;
  logic [XLEN-1:0] pc_f_nxt;
  logic [XLEN-1:0] instr_d_nxt;
  logic [XLEN-1:0] pc_d_nxt;
  logic [XLEN-1:0] pc_plus8_d_nxt;
  logic            valid_d_nxt;
  logic            adel_d_nxt;

  logic [XLEN-1:0] target_c;
  logic            redirect_c;
  logic            misaligned_c;
  logic            accept_c;

  npc_calc u_npc_calc (
    .pc_d       (pc_d),
    .imm16_d    (imm16_d),
    .index26_d  (index26_d),
    .rs_value_d (rs_value_d),
    .pc_control (pc_control),
    .npc_sel    (npc_sel),
    .target_c   (target_c)
  );

  assign imem_addr    = pc_f;
  // pc_control is meaningless while D holds a bubble
  assign redirect_c   = valid_d && is_redirect_sel(pc_control);
  // A misaligned PC never reaches memory, so it completes immediately
  assign misaligned_c = (pc_f[1:0] != 2'b00);
  assign accept_c     = imem_ready || misaligned_c;

  // Next-state and next-register computation
  always_comb begin
    state_nxt        = state;
    saved_target_nxt = saved_target;
    pc_f_nxt         = pc_f;
    instr_d_nxt      = instr_d;
    pc_d_nxt         = pc_d;
    pc_plus8_d_nxt   = pc_plus8_d;
    valid_d_nxt      = valid_d;
    adel_d_nxt       = adel_d;

    if (!stall) begin
      if (accept_c) begin
        instr_d_nxt    = misaligned_c ? NOP_INSTR : imem_rdata;
        adel_d_nxt     = misaligned_c;
        valid_d_nxt    = 1'b1;
        pc_d_nxt       = pc_f;
        pc_plus8_d_nxt = pc_f + XLEN'(8);
        case (state)
          ST_PENDING: begin
            pc_f_nxt  = saved_target;
            state_nxt = ST_NORMAL;
          end
          default: begin
            pc_f_nxt = redirect_c ? target_c : pc_f + XLEN'(4);
          end
        endcase
      end else begin
        instr_d_nxt = NOP_INSTR;
        valid_d_nxt = 1'b0;
        adel_d_nxt  = 1'b0;
        // Bubbling D would lose the redirect, so park it until the
        // delay-slot fetch completes
        if (state == ST_NORMAL && redirect_c) begin
          saved_target_nxt = target_c;
          state_nxt        = ST_PENDING;
        end
      end
    end
  end

  // State, PC and F/D register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_NORMAL;
      saved_target <= '0;
      pc_f         <= RESET_PC;
      instr_d      <= NOP_INSTR;
      pc_d         <= '0;
      pc_plus8_d   <= '0;
      valid_d      <= 1'b0;
      adel_d       <= 1'b0;
    end else begin
      state        <= state_nxt;
      saved_target <= saved_target_nxt;
      pc_f         <= pc_f_nxt;
      instr_d      <= instr_d_nxt;
      pc_d         <= pc_d_nxt;
      pc_plus8_d   <= pc_plus8_d_nxt;
      valid_d      <= valid_d_nxt;
      adel_d       <= adel_d_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Instruction memory returns addr ^ IMEM_KEY.
module tb_fetch_stage;

  localparam logic [31:0] IMEM_KEY = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  pc_control;
  logic        npc_sel;
  logic [15:0] imm16_d;
  logic [25:0] index26_d;
  logic [31:0] rs_value_d;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] pc_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus8_d;
  logic        valid_d;
  logic        adel_d;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ IMEM_KEY;

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .pc_control (pc_control),
    .npc_sel    (npc_sel),
    .imm16_d    (imm16_d),
    .index26_d  (index26_d),
    .rs_value_d (rs_value_d),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .pc_f       (pc_f),
    .instr_d    (instr_d),
    .pc_d       (pc_d),
    .pc_plus8_d (pc_plus8_d),
    .valid_d    (valid_d),
    .adel_d     (adel_d)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; pc_control = 2'd0; npc_sel = 1'b0;
    imm16_d = '0; index26_d = '0; rs_value_d = '0; imem_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (pc_f !== 32'h3000) begin bad++; $display("FAIL reset_pc_f got=%h exp=%h", pc_f, 32'h3000); end
    total++; if (imem_addr !== 32'h3000) begin bad++; $display("FAIL reset_imem_addr got=%h exp=%h", imem_addr, 32'h3000); end
    total++; if (instr_d !== 32'h0) begin bad++; $display("FAIL reset_instr_d got=%h exp=0", instr_d); end
    total++; if (pc_d !== 32'h0) begin bad++; $display("FAIL reset_pc_d got=%h exp=0", pc_d); end
    total++; if (pc_plus8_d !== 32'h0) begin bad++; $display("FAIL reset_pc_plus8_d got=%h exp=0", pc_plus8_d); end
    total++; if (valid_d !== 1'b0 || adel_d !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", valid_d, adel_d); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc_d;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      // Reserved select 3 must act as sequential
      pc_control = (i == 2) ? 2'd3 : 2'd0;
      tick();
      exp_pc_d = 32'h3000 + 32'(4 * i);
      total++; if (pc_f !== exp_pc_d + 32'h4) begin bad++; $display("FAIL seq_pc_f[%0d] got=%h exp=%h", i, pc_f, exp_pc_d + 32'h4); end
      total++; if (pc_d !== exp_pc_d) begin bad++; $display("FAIL seq_pc_d[%0d] got=%h exp=%h", i, pc_d, exp_pc_d); end
      total++; if (pc_plus8_d !== exp_pc_d + 32'h8) begin bad++; $display("FAIL seq_pc8[%0d] got=%h exp=%h", i, pc_plus8_d, exp_pc_d + 32'h8); end
      total++; if (instr_d !== (exp_pc_d ^ IMEM_KEY) || valid_d !== 1'b1) begin bad++; $display("FAIL seq_instr[%0d] got=%h/%b exp=%h/1", i, instr_d, valid_d, exp_pc_d ^ IMEM_KEY); end
    end
    pc_control = 2'd0;
    // Stall in NORMAL holds everything
    stall = 1'b1;
    tick();
    total++; if (pc_f !== 32'h300C || pc_d !== 32'h3008) begin bad++; $display("FAIL seq_stall got=%h/%h exp=0000300c/00003008", pc_f, pc_d); end
    stall = 1'b0;
  endtask

  task automatic test_beq();
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    total++; if (pc_d !== 32'h3010) begin bad++; $display("FAIL beq_setup_pc_d got=%h exp=00003010", pc_d); end
    pc_control = 2'd1; npc_sel = 1'b0; imm16_d = 16'hFFFC;
    tick();
    pc_control = 2'd0;
    total++; if (pc_d !== 32'h3014 || instr_d !== (32'h3014 ^ IMEM_KEY)) begin bad++; $display("FAIL beq_delay_slot got=%h/%h exp=00003014", pc_d, instr_d); end
    total++; if (pc_f !== 32'h3004) begin bad++; $display("FAIL beq_target got=%h exp=00003004", pc_f); end
  endtask

  task automatic test_jal();
    do_reset();
    tick();
    pc_control = 2'd1; npc_sel = 1'b1; index26_d = 26'h0000C10;
    total++; if (pc_plus8_d !== 32'h3008) begin bad++; $display("FAIL jal_link got=%h exp=00003008", pc_plus8_d); end
    tick();
    pc_control = 2'd0;
    total++; if (pc_f !== 32'h3040) begin bad++; $display("FAIL jal_target got=%h exp=00003040", pc_f); end
    total++; if (pc_d !== 32'h3004) begin bad++; $display("FAIL jal_delay_slot got=%h exp=00003004", pc_d); end
  endtask

  task automatic test_jr_pending();
    do_reset();
    tick();
    pc_control = 2'd2; rs_value_d = 32'h3100; imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      // pc_control left at 2: must be ignored while valid_d=0
      total++; if (pc_f !== 32'h3004 || valid_d !== 1'b0 || instr_d !== 32'h0) begin bad++; $display("FAIL jr_wait[%0d] got=%h/%b/%h exp=00003004/0/0", i, pc_f, valid_d, instr_d); end
    end
    imem_ready = 1'b1;
    tick();
    pc_control = 2'd0;
    total++; if (pc_d !== 32'h3004 || valid_d !== 1'b1 || instr_d !== (32'h3004 ^ IMEM_KEY)) begin bad++; $display("FAIL jr_delay_slot got=%h/%b/%h exp=00003004/1", pc_d, valid_d, instr_d); end
    total++; if (pc_f !== 32'h3100) begin bad++; $display("FAIL jr_target got=%h exp=00003100", pc_f); end
    total++; if (pc_plus8_d !== 32'h300C) begin bad++; $display("FAIL jr_pc8 got=%h exp=0000300c", pc_plus8_d); end
    tick();
    total++; if (pc_f !== 32'h3104 || pc_d !== 32'h3100) begin bad++; $display("FAIL jr_after got=%h/%h exp=00003104/00003100", pc_f, pc_d); end
  endtask

  task automatic test_stall_reset();
    do_reset();
    tick();
    pc_control = 2'd2; rs_value_d = 32'h3100; imem_ready = 1'b0;
    tick();
    stall = 1'b1; imem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (pc_f !== 32'h3004 || valid_d !== 1'b0 || instr_d !== 32'h0) begin bad++; $display("FAIL stall_hold[%0d] got=%h/%b/%h exp=00003004/0/0", i, pc_f, valid_d, instr_d); end
    end
    stall = 1'b0; imem_ready = 1'b0;
    tick();
    total++; if (pc_f !== 32'h3004 || valid_d !== 1'b0) begin bad++; $display("FAIL stall_pending got=%h/%b exp=00003004/0", pc_f, valid_d); end
    #2 reset = 1'b1;
    #1;
    total++; if (pc_f !== 32'h3000 || valid_d !== 1'b0 || pc_d !== 32'h0) begin bad++; $display("FAIL async_reset got=%h/%b/%h exp=00003000/0/0", pc_f, valid_d, pc_d); end
    tick();
    reset = 1'b0; pc_control = 2'd0; imem_ready = 1'b1;
    tick();
    // Back in NORMAL: sequential advance, no stale saved target
    total++; if (pc_f !== 32'h3004 || pc_d !== 32'h3000 || valid_d !== 1'b1) begin bad++; $display("FAIL reset_normal got=%h/%h/%b exp=00003004/00003000/1", pc_f, pc_d, valid_d); end
  endtask

  task automatic test_misaligned();
    do_reset();
    tick();
    pc_control = 2'd2; rs_value_d = 32'h3102;
    tick();
    pc_control = 2'd0; imem_ready = 1'b0;
    total++; if (pc_f !== 32'h3102) begin bad++; $display("FAIL mis_target got=%h exp=00003102", pc_f); end
    tick();
    total++; if (adel_d !== 1'b1 || instr_d !== 32'h0 || pc_d !== 32'h3102 || valid_d !== 1'b1) begin bad++; $display("FAIL mis_adel got=%b/%h/%h/%b exp=1/0/00003102/1", adel_d, instr_d, pc_d, valid_d); end
    total++; if (pc_f !== 32'h3106 || pc_plus8_d !== 32'h310A) begin bad++; $display("FAIL mis_next got=%h/%h exp=00003106/0000310a", pc_f, pc_plus8_d); end
  endtask

  task automatic test_wrap();
    do_reset();
    tick();
    pc_control = 2'd2; rs_value_d = 32'hFFFF_FFFC;
    tick();
    pc_control = 2'd0;
    tick();
    total++; if (pc_d !== 32'hFFFF_FFFC || pc_plus8_d !== 32'h4 || pc_f !== 32'h0) begin bad++; $display("FAIL wrap got=%h/%h/%h exp=fffffffc/00000004/00000000", pc_d, pc_plus8_d, pc_f); end
    total++; if (adel_d !== 1'b0 || instr_d !== (32'hFFFF_FFFC ^ IMEM_KEY)) begin bad++; $display("FAIL wrap_instr got=%b/%h exp=0/%h", adel_d, instr_d, 32'hFFFF_FFFC ^ IMEM_KEY); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_beq();
    test_jal();
    test_jr_pending();
    test_stall_reset();
    test_misaligned();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
